// File: rtl/ram_stream_reader.sv
// Streams a contiguous, wrap-around range of RAM words out as a valid/ready beat stream.
// A 2-entry skid buffer hides the 1-cycle RAM read latency and absorbs backpressure.
module ram_stream_reader #(
    parameter  int RAM_SIZE   = 64,
    parameter  int DATA_WIDTH = 8,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE),
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  push_cnt_q, push_cnt_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  last_q [2];

    logic                  push, pop, issue_ok, issue, push_last;
    logic [2:0]            occ;
    logic [LEN_WIDTH-1:0]  len_sel;
    logic [ADDR_WIDTH-1:0] addr_inc;

    assign len_sel  = (length > LEN_WIDTH'(RAM_SIZE)) ? LEN_WIDTH'(RAM_SIZE) : length;
    assign addr_inc = (r_addr_q == ADDR_WIDTH'(RAM_SIZE - 1)) ? '0 : r_addr_q + ADDR_WIDTH'(1);

    // A word returns one cycle after its read is issued; it is pushed that cycle.
    assign push      = inflight_q;
    assign pop       = (count_q != 2'd0) && m_ready;
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_ok  = (occ < 3'd2);
    assign issue     = (state_q == READ) && issue_ok;
    assign push_last = (push_cnt_q == len_q - LEN_WIDTH'(1));

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        wr_ptr_d   = wr_ptr_q ^ push;
        push_cnt_d = push ? push_cnt_q + LEN_WIDTH'(1) : push_cnt_q;
        inflight_d = issue;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        r_addr_d    = r_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = len_sel;
                    r_addr_d    = base_addr;
                    issue_cnt_d = '0;
                    state_d     = (len_sel == '0) ? FIN : READ;
                end
            end
            READ: begin
                if (issue) begin
                    r_addr_d    = addr_inc;
                    issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
                    if (issue_cnt_q + LEN_WIDTH'(1) == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is being accepted, so done follows it directly.
                if (!inflight_q && count_d == 2'd0) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            push_cnt_q  <= '0;
            r_addr_q    <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            push_cnt_q  <= (state_q == IDLE) ? '0 : push_cnt_d;
            r_addr_q    <= r_addr_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            if (push) begin
                data_q[wr_ptr_q] <= ram_data;
                last_q[wr_ptr_q] <= push_last;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign r_addr  = r_addr_q;
    assign m_valid = (count_q != 2'd0);
    assign m_data  = data_q[rd_ptr_q];
    assign m_last  = m_valid && last_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioural 1-cycle-latency RAM preloaded mem[i]=i.
module tb_ram_stream_reader;

    localparam int RS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] base_addr;
    logic [6:0] length;
    logic       busy, done;
    logic [5:0] r_addr;
    logic [7:0] ram_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    logic [7:0] mem [RS];

    int checks = 0;
    int errors = 0;

    ram_stream_reader #(.RAM_SIZE(RS), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .r_addr(r_addr), .ram_data(ram_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_data <= mem[r_addr];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start command sampled at the end of cycle 0; returns #1 into cycle 1.
    task automatic do_start(input int b, input int l);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 6'(b);
        length    = 7'(l);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_xfer(input int b, input int l, input int mode, input int n_exp,
                            input bit spur, input string tag);
        int   q_data [$];
        int   q_last [$];
        int   stall_viol = 0;
        int   max_ahead  = 0;
        bit   stall_prev = 1'b0;
        bit   done_seen  = 1'b0;
        int   prev_data  = 0;
        int   prev_last  = 0;
        int   ahead, n;
        do_start(b, l);
        for (int cyc = 1; cyc < 400 && !done_seen; cyc++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 3) == 1);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (spur && cyc >= 3) begin
                start     = 1'b1;
                base_addr = 6'd20;
                length    = 7'd3;
            end
            @(negedge clk);
            if (stall_prev && (int'(m_data) != prev_data || int'(m_last) != prev_last))
                stall_viol++;
            ahead = ((int'(r_addr) - b + RS) % RS) - q_data.size();
            if (ahead > max_ahead) max_ahead = ahead;
            if (m_valid && m_ready) begin
                q_data.push_back(int'(m_data));
                q_last.push_back(int'(m_last));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = int'(m_data);
            prev_last  = int'(m_last);
            if (done) done_seen = 1'b1;
            else if (!done_seen) @(posedge clk) #1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, int'(done_seen), 1);
        chk({tag, "_beats"}, q_data.size(), n_exp);
        n = (q_data.size() < n_exp) ? q_data.size() : n_exp;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, q_data[i], (b + i) % RS);
            chk({tag, "_last"}, q_last[i], (i == n_exp - 1) ? 1 : 0);
        end
        chk({tag, "_stall_stable_viol"}, stall_viol, 0);
        chk({tag, "_ahead_le2"}, int'(max_ahead <= 2), 1);
        @(negedge clk);
        chk({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < RS; i++) mem[i] = 8'(i);
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_last", int'(m_last), 0);
        chk("rst_raddr", int'(r_addr), 0);
        chk("rst_mdata", int'(m_data), 0);

        // Cycle-exact: base 4, len 5.
        m_ready = 1'b1;
        do_start(4, 5);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_c%0d", k), int'(m_valid), (k >= 3 && k <= 7) ? 1 : 0);
            if (k >= 3 && k <= 7) chk($sformatf("t1_data_c%0d", k), int'(m_data), k + 1);
            chk($sformatf("t1_last_c%0d", k), int'(m_last), (k == 7) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", k), int'(done), (k == 8) ? 1 : 0);
            chk($sformatf("t1_busy_c%0d", k), int'(busy), (k <= 8) ? 1 : 0);
            if (k == 1) chk("t1_raddr_c1", int'(r_addr), 4);
        end

        run_xfer(62, 4, 0, 4, 1'b0, "wrap");
        run_xfer(5, 8, 1, 8, 1'b0, "bp_toggle");
        run_xfer(40, 8, 2, 8, 1'b0, "bp_random");
        run_xfer(0, 100, 0, 64, 1'b0, "len_clip");
        run_xfer(10, 6, 0, 6, 1'b1, "start_busy");

        // Zero length: done in cycle 1, no beats.
        do_start(7, 0);
        @(negedge clk);
        chk("len0_done_c1", int'(done), 1);
        chk("len0_valid_c1", int'(m_valid), 0);
        @(negedge clk);
        chk("len0_done_c2", int'(done), 0);
        chk("len0_busy_c2", int'(busy), 0);
        chk("len0_valid_c2", int'(m_valid), 0);

        // Reset mid-transfer with downstream stalled.
        m_ready = 1'b0;
        do_start(0, 10);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rstmid_valid_before", int'(m_valid), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", int'(m_valid), 0);
        chk("rstmid_busy", int'(busy), 0);
        run_xfer(0, 2, 0, 2, 1'b0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the on-chip dual-port RAM (1-cycle registered read: `data_out` valid the cycle after `r_addr` is sampled).
- On a start command, walks a contiguous, wrap-around address range and emits each word as a valid/ready stream with a last-beat flag.
- Hides the RAM read latency and absorbs downstream backpressure with a 2-entry skid buffer.
- Sustains one word per cycle while `m_ready` is held high.

Parameters:
- RAM_SIZE, 64, number of RAM words; must match the attached RAM.
- DATA_WIDTH, 8, word width; must match the attached RAM.
- ADDR_WIDTH, $clog2(RAM_SIZE), localparam, RAM address width.
- LEN_WIDTH, ADDR_WIDTH+1, localparam, width of the transfer length.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe; sampled only when busy=0.
- base_addr  in  ADDR_WIDTH  first RAM address; captured with start.
- length  in  LEN_WIDTH  word count; captured with start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- r_addr  out  ADDR_WIDTH  RAM read address; registered.
- ram_data  in  DATA_WIDTH  RAM `data_out`.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from downstream.
- m_last  out  1  marks the final beat of the transfer.

Behaviour:
- Reset:
  - busy, done, m_valid and m_last are 0; r_addr and m_data are 0; FSM goes to IDLE.
  - Skid buffer count, in-flight flag and counters are cleared.
  - Reset mid-transfer discards buffered and in-flight data; ram_data is ignored on the cycle after reset.
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE: on start=1, capture base_addr and len = min(length, RAM_SIZE).
    - len=0 → FIN.
    - Otherwise → READ, with r_addr=base_addr and issue counter = 0.
  - READ: the block issues a read in any cycle where issue_ok=1.
    - issue_ok = (count + inflight − pop) < 2, where count = buffer occupancy, inflight = read issued last cycle, pop = m_valid & m_ready.
    - On issue: r_addr advances to r_addr+1, wrapping RAM_SIZE−1 → 0 (explicit wrap, correct for non-power-of-2 RAM_SIZE); issue counter increments.
    - After the len-th issue → DRAIN.
  - DRAIN: wait until inflight=0 and count=0 → FIN.
  - FIN: done=1 for exactly one cycle → IDLE.
- busy:
  - 1 from the cycle after start is accepted through the FIN cycle inclusive.
  - start while busy=1, including the FIN cycle, is ignored.
- Read pipeline:
  - A read issued in cycle t (r_addr stable during t) returns on ram_data during t+1.
  - That word is written into the buffer at the end of t+1.
- Skid buffer:
  - 2-entry FIFO; m_data and m_valid come from the head entry.
  - m_valid = (count > 0), registered.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - Push and pop may occur in the same cycle; count is unchanged.
  - The buffer never overflows, guaranteed by issue_ok.
- m_last: 1 with the beat whose index = len−1; tagged at push time by the beat counter.
- Latency: start sampled in cycle 0 → r_addr=base in cycle 1 → first m_valid in cycle 3.
- Throughput: with m_ready held 1, one beat per cycle.
  - Last beat of an N-word transfer appears in cycle N+2.
  - done appears in cycle N+3.
- Word order: strictly ascending addresses modulo RAM_SIZE; no duplicates, no drops under any m_ready pattern.

Test Plan:
- Preload mem[i]=i. start, base=4, len=5, m_ready=1 → m_data 4,5,6,7,8 on cycles 3..7; m_last on cycle 7; done on cycle 8; busy 0 on cycle 9.
- Wrap: base=62, len=4, RAM_SIZE=64 → data 62,63,0,1; m_last on the 4th beat.
- Backpressure: len=8, m_ready toggling 1,0,0,1,… and random → exact ordered 8 words; m_data stable during every stall; r_addr never more than 2 words ahead of the accepted count.
- Edge lengths:
  - len=0 → done pulses in cycle 1; no m_valid.
  - length=100 with RAM_SIZE=64 → exactly 64 beats.
  - start asserted during busy → ignored; no change in the beat count.
- Reset during beat 3 of a len=10 transfer with m_ready=0 → next cycle m_valid=0, busy=0; a new start base=0, len=2 then yields only words 0,1.
